ds_capture_fifo: RTL and testbench

DS_CAPTURE_FIFO -- requirements
Module: ds_capture_fifo

---
 rtl/uberclock_cap_pkg.sv | 21 ++
 rtl/ds_capture_ram.sv | 35 +++
 rtl/ds_capture_fifo.sv | 136 +++++++++++++
 tb/tb_ds_capture_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uberclock_cap_pkg.sv
//------------------------------------------------------------------------------
// uberclock_cap_pkg : capture state encoding and default sample/address widths
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uberclock_cap_pkg;

  localparam int DEFAULT_DW = 16;
  localparam int DEFAULT_AW = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/ds_capture_ram.sv
//------------------------------------------------------------------------------
// ds_capture_ram : simple dual-port DEPTH x DW sample store, read-first
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ds_capture_ram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge sys_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-first: a pop of the slot being overwritten returns the old sample.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/ds_capture_fifo.sv
//------------------------------------------------------------------------------
// ds_capture_fifo : armed capture FIFO for downsampled samples with CPU pop port
// Optional rising-edge trigger: define UBERCLOCK_CAP_TRIGGER_EN.   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ds_capture_fifo
  import uberclock_cap_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic [DW-1:0] s_data,
  input  logic          s_ce,
  input  logic          arm,
  input  logic [AW:0]   capture_len,
  input  logic [DW-1:0] trig_level,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [AW:0]   level,
  output logic [1:0]    state,
  output logic          done,
  output logic [15:0]   overflow_cnt
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(2**AW);

  cap_state_t    cur_state, nxt_state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   lvl, cnt, cnt_inc, len_eff;
  logic [15:0]   ovf;
  logic          trig_hit, take, full, push, pop, drop, last;

`ifdef UBERCLOCK_CAP_TRIGGER_EN
  logic [DW-1:0] prev_sample;

  assign trig_hit = s_ce && ($signed(prev_sample) < $signed(trig_level)) &&
                    ($signed(s_data) >= $signed(trig_level));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)       prev_sample <= {1'b1, {(DW-1){1'b0}}};
    else if (arm)  prev_sample <= {1'b1, {(DW-1){1'b0}}};
    else if (s_ce) prev_sample <= s_data;
  end
`else
  logic unused_trig;
  assign unused_trig = ^trig_level;
  assign trig_hit    = 1'b0;
`endif

  assign len_eff = (capture_len == '0) ? DEPTH_L : capture_len;
  assign cnt_inc = cnt + 1'b1;
  assign take    = !arm && s_ce &&
                   ((cur_state == CAPTURE) || ((cur_state == ARMED) && trig_hit));
  assign full    = (lvl == DEPTH_L);
  assign pop     = !arm && rd_en && (lvl != '0);
  assign push    = take && (!full || pop);
  assign drop    = take && full && !pop;
  assign last    = take && (cnt_inc == len_eff);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    if (arm) begin
      nxt_state = ARMED;
    end else begin
      case (cur_state)
`ifdef UBERCLOCK_CAP_TRIGGER_EN
        ARMED:   if (trig_hit) nxt_state = last ? DONE : CAPTURE;
`else
        ARMED:   nxt_state = CAPTURE;
`endif
        CAPTURE: if (last) nxt_state = DONE;
        default: nxt_state = cur_state;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl      <= '0;
      cnt      <= '0;
      ovf      <= '0;
      rd_valid <= 1'b0;
    end else if (arm) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl      <= '0;
      cnt      <= '0;
      ovf      <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (take) cnt    <= cnt_inc;
      if (drop && (ovf != 16'hFFFF)) ovf <= ovf + 16'd1;
      case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  ds_capture_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .sys_clk (sys_clk),
    .rst     (rst),
    .we      (push),
    .waddr   (wr_ptr),
    .wdata   (s_data),
    .re      (pop),
    .raddr   (rd_ptr),
    .rdata   (rd_data)
  );

  assign level        = lvl;
  assign state        = cur_state;
  assign done         = (cur_state == DONE);
  assign overflow_cnt = ovf;

endmodule

`default_nettype wire

// File: tb/tb_ds_capture_fifo.sv
//------------------------------------------------------------------------------
// tb_ds_capture_fifo : vector table plus scoreboarded capture/pop sequences
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ds_capture_fifo;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_ce = 1'b0;
  logic          arm = 1'b0;
  logic [AW:0]   capture_len = '0;
  logic [DW-1:0] trig_level = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   level;
  logic [1:0]    state;
  logic          done;
  logic [15:0]   overflow_cnt;

  ds_capture_fifo #(.DW(DW), .AW(AW)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_ce         (s_ce),
    .arm          (arm),
    .capture_len  (capture_len),
    .trig_level   (trig_level),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .level        (level),
    .state        (state),
    .done         (done),
    .overflow_cnt (overflow_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int            n_pass = 0;
  int            n_total = 0;
  logic [DW-1:0] sb[$];

  typedef struct {
    logic          a;
    logic          ce;
    logic [DW-1:0] d;
    logic          rd;
    logic [1:0]    st;
    logic [AW:0]   lvl;
    logic          rv;
    logic [DW-1:0] rdat;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic ce, input logic [DW-1:0] d, input logic rd);
    arm = a; s_ce = ce; s_data = d; rd_en = rd;
    tick();
    arm = 1'b0; s_ce = 1'b0; rd_en = 1'b0;
  endtask

  task automatic strobe(input logic [DW-1:0] d, input logic stored);
    drive(1'b0, 1'b1, d, 1'b0);
    if (stored) sb.push_back(d);
  endtask

  task automatic pop_check(input string name);
    logic [DW-1:0] exp;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      drive(1'b0, 1'b0, '0, 1'b1);
      check({name, "_rv"}, 32'(rd_valid), 32'd1);
      check({name, "_data"}, 32'(rd_data), 32'(exp));
    end
  endtask

  task automatic start(input logic [AW:0] len);
    capture_len = len;
    sb.delete();
    drive(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(overflow_cnt), 32'd0);
    check("rst_rv", 32'(rd_valid), 32'd0);
    check("rst_rdata", 32'(rd_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

`ifndef UBERCLOCK_CAP_TRIGGER_EN
    // arm, ce, data, rd  ->  state, level, rd_valid, rd_data
    vt[0] = '{1'b0, 1'b0, 16'd0,  1'b1, 2'd0, 11'd0, 1'b0, 16'd0};
    vt[1] = '{1'b1, 1'b1, 16'd7,  1'b0, 2'd1, 11'd0, 1'b0, 16'd0};
    vt[2] = '{1'b0, 1'b1, 16'd9,  1'b0, 2'd2, 11'd0, 1'b0, 16'd0};
    vt[3] = '{1'b0, 1'b1, 16'd11, 1'b0, 2'd2, 11'd1, 1'b0, 16'd0};
    vt[4] = '{1'b0, 1'b0, 16'd0,  1'b1, 2'd2, 11'd0, 1'b1, 16'd11};
    vt[5] = '{1'b0, 1'b1, 16'd12, 1'b1, 2'd2, 11'd1, 1'b0, 16'd11};
    vt[6] = '{1'b0, 1'b1, 16'd13, 1'b0, 2'd3, 11'd2, 1'b0, 16'd11};
    vt[7] = '{1'b0, 1'b1, 16'd14, 1'b1, 2'd3, 11'd1, 1'b1, 16'd12};
    vt[8] = '{1'b1, 1'b0, 16'd0,  1'b1, 2'd1, 11'd0, 1'b0, 16'd12};
    vt[9] = '{1'b0, 1'b0, 16'd0,  1'b0, 2'd2, 11'd0, 1'b0, 16'd12};
    capture_len = 11'd3;
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].a, vt[i].ce, vt[i].d, vt[i].rd);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].st));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vt[i].lvl));
      check($sformatf("vec%0d_rv", i), 32'(rd_valid), 32'(vt[i].rv));
      check($sformatf("vec%0d_rdata", i), 32'(rd_data), 32'(vt[i].rdat));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].st == 2'd3));
    end

    // Basic: 8 samples, one strobe every 4 cycles, then drain
    start(11'd8);
    check("basic_armed", 32'(state), 32'd1);
    tick();
    check("basic_capture", 32'(state), 32'd2);
    for (int i = 1; i <= 8; i++) begin
      strobe(16'(i), 1'b1);
      if (i < 8) repeat (3) tick();
    end
    check("basic_state", 32'(state), 32'd3);
    check("basic_done", 32'(done), 32'd1);
    check("basic_level", 32'(level), 32'd8);
    for (int i = 1; i <= 8; i++) pop_check($sformatf("basic_pop%0d", i));
    check("basic_drained", 32'(level), 32'd0);

    drive(1'b0, 1'b0, '0, 1'b1);
    check("empty_rv", 32'(rd_valid), 32'd0);
    check("empty_level", 32'(level), 32'd0);
    check("empty_rdata_hold", 32'(rd_data), 32'd8);

    // capture_len=0 means DEPTH: strobes after the 1024th are ignored
    start(11'd0);
    tick();
    for (int i = 0; i < 1030; i++) strobe(16'(i + 1), i < 1024);
    check("len0_level", 32'(level), 32'd1024);
    check("len0_ovf", 32'(overflow_cnt), 32'd0);
    check("len0_state", 32'(state), 32'd3);

    start(11'd1030);
    tick();
    for (int i = 0; i < 1030; i++) strobe(16'(i + 1), i < 1024);
    check("ovf_level", 32'(level), 32'd1024);
    check("ovf_cnt", 32'(overflow_cnt), 32'd6);
    check("ovf_state", 32'(state), 32'd3);
    pop_check("ovf_first_pop");
    check("ovf_level_after_pop", 32'(level), 32'd1023);

    // Full FIFO, strobe and pop in the same cycle
    start(11'd1100);
    tick();
    for (int i = 0; i < 1026; i++) strobe(16'(i + 1), i < 1024);
    check("full_level", 32'(level), 32'd1024);
    check("full_ovf", 32'(overflow_cnt), 32'd2);
    check("full_state", 32'(state), 32'd2);
    begin
      logic [DW-1:0] exp;
      exp = sb.pop_front();
      drive(1'b0, 1'b1, 16'd5000, 1'b1);
      sb.push_back(16'd5000);
      check("simul_rv", 32'(rd_valid), 32'd1);
      check("simul_data", 32'(rd_data), 32'(exp));
      check("simul_level", 32'(level), 32'd1024);
      check("simul_ovf", 32'(overflow_cnt), 32'd2);
    end
    pop_check("simul_next_pop");
    check("simul_level2", 32'(level), 32'd1023);
    drive(1'b1, 1'b0, '0, 1'b1);
    check("flush_level", 32'(level), 32'd0);
    check("flush_ovf", 32'(overflow_cnt), 32'd0);
    check("flush_rv", 32'(rd_valid), 32'd0);

    // Re-arm after 5 of 10 samples
    start(11'd10);
    tick();
    for (int i = 0; i < 5; i++) strobe(16'(100 + i), 1'b1);
    check("rearm_pre_level", 32'(level), 32'd5);
    drive(1'b1, 1'b1, 16'd77, 1'b0);
    check("rearm_level", 32'(level), 32'd0);
    check("rearm_ovf", 32'(overflow_cnt), 32'd0);
    check("rearm_state", 32'(state), 32'd1);

    // Asynchronous reset in the middle of a capture and a pop
    sb.delete();
    tick();
    for (int i = 0; i < 3; i++) strobe(16'(21 + i), 1'b1);
    pop_check("prereset_pop");
    s_ce = 1'b1; s_data = 16'd99; rd_en = 1'b1;
    @(negedge sys_clk);
    rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_ovf", 32'(overflow_cnt), 32'd0);
    check("arst_rv", 32'(rd_valid), 32'd0);
    check("arst_rdata", 32'(rd_data), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    tick();
    s_ce = 1'b0; rd_en = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_level", 32'(level), 32'd0);
`else
    // Rising crossing of 100 starts the capture with the crossing sample
    trig_level = 16'd100;
    start(11'd5);
    begin
      logic [DW-1:0] smp [5];
      logic [1:0]    est [5];
      logic [AW:0]   elv [5];
      smp[0] = -16'sd50; est[0] = 2'd1; elv[0] = 11'd0;
      smp[1] = 16'sd50;  est[1] = 2'd1; elv[1] = 11'd0;
      smp[2] = 16'sd99;  est[2] = 2'd1; elv[2] = 11'd0;
      smp[3] = 16'sd100; est[3] = 2'd2; elv[3] = 11'd1;
      smp[4] = 16'sd200; est[4] = 2'd2; elv[4] = 11'd2;
      for (int i = 0; i < 5; i++) begin
        strobe(smp[i], i >= 3);
        check($sformatf("trig%0d_state", i), 32'(state), 32'(est[i]));
        check($sformatf("trig%0d_level", i), 32'(level), 32'(elv[i]));
        tick();
      end
    end
    pop_check("trig_first_pop");
    pop_check("trig_second_pop");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
